branch_hazard_ctrl: RTL
=======================

// Module: branch_hazard_ctrl
// PURPOSE
//  Sequences the ID-stage branch compare. Detects RAW hazards on the branch operands and selects
//  MEM/WB forwarding for the comparator inputs. Stalls IF/ID/PC for the required cycles, then
//  issues the redirect and the IF/ID flush when a branch resolves taken.
//  Sits between the hazard unit and the ID-stage comparator.
// PARAMETERS
//  REG_AW        5   register-address width
//  LOAD_STALLS   2   stall cycles when the producer is a load in EX
//  ALU_STALLS    1   stall cycles when the producer is an ALU op in EX, or a load in MEM
// PORTS
//  clk_i           in   1       clock; all state on rising edge
//  rst_i           in   1       synchronous, active-high reset
//  id_branch_i     in   1       branch instruction (BEQ) in ID
//  id_rs1_i        in   REG_AW  branch source 1
//  id_rs2_i        in   REG_AW  branch source 2
//  ex_regwrite_i   in   1       EX instruction writes rd
//  ex_memread_i    in   1       EX instruction is a load
//  ex_rd_i         in   REG_AW  EX destination
//  mem_regwrite_i  in   1       MEM instruction writes rd
//  mem_memread_i   in   1       MEM instruction is a load
//  mem_rd_i        in   REG_AW  MEM destination
//  wb_regwrite_i   in   1       WB instruction writes rd
//  wb_rd_i         in   REG_AW  WB destination
//  cmp_eq_i        in   1       comparator equal result (forwarded operands)
//  stall_o         out  1       hold PC and IF/ID, insert bubble into ID/EX
//  pc_src_o        out  1       select branch target
//  ifid_flush_o    out  1       zero the IF/ID register
//  fwd_a_o         out  2       comparator src1 mux: 00 regfile, 01 MEM ALU result, 10 WB data
//  fwd_b_o         out  2       same encoding for src2
// BEHAVIOUR
//  - match(rs,rd,we) = we && rd==rs && rs!=0. x0 never causes a hazard or a forward.
//  - Hazard N (required stall count) for a branch in ID, largest term wins:
//      EX match with ex_memread_i -> LOAD_STALLS; EX ALU match -> ALU_STALLS;
//      MEM match with mem_memread_i -> ALU_STALLS; otherwise 0.
//  - FSM states: RUN, STALL; 2-bit down-counter cnt.
//  - RUN, id_branch_i=1, N>0: stall_o=1; pc_src_o=0 and ifid_flush_o=0 regardless of cmp_eq_i.
//      If N>1, next state is STALL with cnt=N-1. If N=1, stay in RUN; hazard is re-evaluated next cycle.
//  - STALL: stall_o=1 and cnt decrements. When cnt==1, next state is RUN. Inputs other than rst_i are ignored.
//  - RUN, id_branch_i=1, N=0: branch resolves this cycle with zero latency (combinational).
//      pc_src_o = ifid_flush_o = cmp_eq_i; stall_o=0.
//  - RUN with no branch: all control outputs are 0.
//  - Forwarding is combinational in every state; fwd_x_o is 0 when id_branch_i=0.
//      MEM non-load match -> 01, else WB match -> 10, else 00. MEM has priority over WB.
//  - A hazard and a taken compare in the same cycle: stall wins; no redirect.
//  - rst_i=1: state=RUN, cnt=0, all outputs 0 that cycle, including any mid-stall. Reset dominates.
//  - The cnt of a load in EX followed by the same load in MEM is never double-counted:
//      the STALL sequence covers it, and RUN re-evaluation finds N=0.
// CONFIGURATION
//  BRANCH_CTRL_STATS_EN defined: adds outputs br_taken_cnt_o[31:0] and br_stall_cnt_o[31:0].
//    br_taken_cnt_o increments on each cycle with pc_src_o=1.
//    br_stall_cnt_o increments on each cycle with stall_o=1.
//    Both reset to 0 and wrap modulo 2^32.
//  Undefined: neither the ports nor the counters exist; all other behaviour is identical.
// STRUCTURE
//  Package branch_ctrl_pkg: state enum (RUN, STALL) and FWD_RF/FWD_MEM/FWD_WB constants (2'b00/01/10).
//  Sub-module branch_hazard_detect: combinational match logic producing N, fwd_a and fwd_b.
//  The top level holds the FSM, the counter and the optional stats counters.
// TESTING
//  1. Branch x1==x2, no hazards, cmp_eq_i=1 -> same cycle pc_src_o=1, ifid_flush_o=1, stall_o=0.
//  2. EX load rd=x5, branch rs1=x5 -> stall_o=1 for 2 cycles, then resolves on the 3rd cycle.
//  3. EX ALU rd=x3, branch rs2=x3 -> 1 stall cycle. Next cycle MEM match -> fwd_b_o=01.
//  4. MEM rd=x7 and WB rd=x7, branch rs1=x7 -> fwd_a_o=01 (MEM priority). EX rd=x0 with rs=x0 -> no stall.
//  5. rst_i asserted in STALL with cnt=1 -> next cycle RUN, all outputs 0.
//     With STATS_EN: 3 taken branches and 2 stalls -> counters read 3 and 2.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared types and forwarding-select constants for the branch hazard controller
package branch_ctrl_pkg;

  // Controller sequencing state
  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Comparator operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/branch_hazard_detect.sv
// rtl/branch_hazard_detect.sv - combinational RAW match logic: required stall count and operand forwarding selects
module branch_hazard_detect
  import branch_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALLS = 2,
  parameter int ALU_STALLS  = 1
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        need_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  localparam logic [1:0] LOAD_N = 2'(LOAD_STALLS);
  localparam logic [1:0] ALU_N  = 2'(ALU_STALLS);

  // x0 is hardwired zero, so it never produces a dependency
  function automatic logic match(input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd,
                                 input logic              we);
    return we && (rd == rs) && (rs != '0);
  endfunction

  // A MEM-stage load has no ALU result yet, so only non-load MEM producers forward
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (match(rs, mem_rd_i, mem_regwrite_i) && !mem_memread_i)
      return FWD_MEM;
    else if (match(rs, wb_rd_i, wb_regwrite_i))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  logic ex_hit;
  logic mem_ld_hit;

  assign ex_hit     = match(id_rs1_i, ex_rd_i, ex_regwrite_i) |
                      match(id_rs2_i, ex_rd_i, ex_regwrite_i);
  assign mem_ld_hit = mem_memread_i &
                      (match(id_rs1_i, mem_rd_i, mem_regwrite_i) |
                       match(id_rs2_i, mem_rd_i, mem_regwrite_i));

  // Required stall count: the largest applicable hazard term wins
  always_comb begin
    need_o = 2'd0;
    if (mem_ld_hit && ALU_N > need_o)
      need_o = ALU_N;
    if (ex_hit && !ex_memread_i && ALU_N > need_o)
      need_o = ALU_N;
    if (ex_hit && ex_memread_i && LOAD_N > need_o)
      need_o = LOAD_N;
  end

  assign fwd_a_o = fwd_sel(id_rs1_i);
  assign fwd_b_o = fwd_sel(id_rs2_i);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch sequencer (stall, redirect, flush, forwarding); optional stats via BRANCH_CTRL_STATS_EN
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALLS = 2,
  parameter int ALU_STALLS  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_branch_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              cmp_eq_i,
  output logic              stall_o,
  output logic              pc_src_o,
  output logic              ifid_flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [31:0]       br_taken_cnt_o,
  output logic [31:0]       br_stall_cnt_o
`endif
);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  branch_hazard_detect #(
    .REG_AW      (REG_AW),
    .LOAD_STALLS (LOAD_STALLS),
    .ALU_STALLS  (ALU_STALLS)
  ) u_detect (
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_regwrite_i  (ex_regwrite_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rd_i        (ex_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .mem_memread_i  (mem_memread_i),
    .mem_rd_i       (mem_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .need_o         (need),
    .fwd_a_o        (fwd_a_raw),
    .fwd_b_o        (fwd_b_raw)
  );

  // State and stall counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: multi-cycle hazards park in STALL; a single-cycle hazard re-evaluates from RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (id_branch_i && need > 2'd1) begin
          state_d = STALL;
          cnt_d   = need - 2'd1;
        end
      end
      STALL: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs: reset forces everything low; a hazard suppresses any redirect
  always_comb begin
    stall_o      = 1'b0;
    pc_src_o     = 1'b0;
    ifid_flush_o = 1'b0;
    fwd_a_o      = FWD_RF;
    fwd_b_o      = FWD_RF;
    if (!rst_i) begin
      if (id_branch_i) begin
        fwd_a_o = fwd_a_raw;
        fwd_b_o = fwd_b_raw;
      end
      case (state_q)
        RUN: begin
          if (id_branch_i) begin
            if (need != 2'd0) begin
              stall_o = 1'b1;
            end else begin
              pc_src_o     = cmp_eq_i;
              ifid_flush_o = cmp_eq_i;
            end
          end
        end
        STALL:   stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Event counters for taken redirects and stall cycles, wrapping naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_taken_cnt_o <= 32'd0;
      br_stall_cnt_o <= 32'd0;
    end else begin
      if (pc_src_o)
        br_taken_cnt_o <= br_taken_cnt_o + 32'd1;
      if (stall_o)
        br_stall_cnt_o <= br_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
